// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl
// Read-side initiator for the 640x72b weight SRAM. A start command streams
// one layer's weight words out of the SRAM in address order and delivers
// them over a valid/ready handshake. A 2-entry output buffer absorbs the
// SRAM's 1-cycle read latency and downstream back-pressure.
//
// Optional feature: define WFETCH_CHECKSUM_EN to build the running byte-sum
// checksum on w_checksum. Otherwise w_checksum is tied to 0.
//
// Ports
//   clk, srst        clock, synchronous active-high reset
//   start, layer     fetch request (sampled in IDLE only), layer select
//   busy, done       fetch in progress, one-cycle completion pulse
//   sram_csb         SRAM read strobe, active-low
//   sram_raddr       SRAM read address
//   sram_rdata       SRAM read data, valid the cycle after the read
//   w_valid/w_ready  output handshake
//   w_data           weight word
//   w_index          word offset within the layer
//   w_last           final word of the layer
//   w_checksum       running checksum of handshaked bytes
module weight_fetch_ctrl #(
   parameter int unsigned WEIGHT_PER_ADDR = 9,
   parameter int unsigned BW_PER_PARAM    = 8,
   parameter int unsigned ADDR_BW         = 10
) (
   input  logic                                      clk,
   input  logic                                      srst,
   input  logic                                      start,
   input  logic [1:0]                                layer,
   output logic                                      busy,
   output logic                                      done,
   output logic                                      sram_csb,
   output logic [ADDR_BW-1:0]                        sram_raddr,
   input  logic [WEIGHT_PER_ADDR*BW_PER_PARAM-1:0]   sram_rdata,
   output logic                                      w_valid,
   input  logic                                      w_ready,
   output logic [WEIGHT_PER_ADDR*BW_PER_PARAM-1:0]   w_data,
   output logic [ADDR_BW-1:0]                        w_index,
   output logic                                      w_last,
   output logic [15:0]                               w_checksum
);

   localparam int unsigned DATA_W = WEIGHT_PER_ADDR * BW_PER_PARAM;
   localparam logic [ADDR_BW-1:0] ADDR_ONE = ADDR_BW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state;
   logic [ADDR_BW-1:0]  last_off_q;      // count-1 for the active layer
   logic [ADDR_BW-1:0]  issued_q;        // reads issued so far
   logic [1:0]          occ_q;           // buffer occupancy (0..2)
   logic                inflight_q;      // read issued last cycle, data on sram_rdata now
   logic [ADDR_BW-1:0]  inflight_idx_q;
   logic                inflight_last_q;
   logic [DATA_W-1:0]   skid_data_q;     // second buffer entry behind the head
   logic [ADDR_BW-1:0]  skid_idx_q;
   logic                skid_last_q;

   logic                pop_c;
   logic                push_c;
   logic                issue_c;
   logic                last_issue_c;
   logic                start_ok_c;
   logic [ADDR_BW-1:0]  base_c;
   logic [ADDR_BW-1:0]  last_off_c;
   logic [1:0]          occ_next_c;

   // Fixed layer map: base address and last word offset
   always_comb begin
      base_c     = '0;
      last_off_c = '0;
      case (layer)
         2'd0:    begin base_c = ADDR_BW'(0);  last_off_c = ADDR_BW'(15);  end
         2'd1:    begin base_c = ADDR_BW'(16); last_off_c = ADDR_BW'(47);  end
         2'd2:    begin base_c = ADDR_BW'(64); last_off_c = ADDR_BW'(575); end
         default: begin base_c = '0;           last_off_c = '0;            end
      endcase
   end

   // Handshake, issue gating and buffer bookkeeping.
   // A read is only issued when the buffer is guaranteed a free slot for it
   // after this cycle's pop, so the strobe depends on w_ready combinationally.
   always_comb begin
      pop_c        = w_valid && w_ready;
      push_c       = inflight_q;
      start_ok_c   = (state == S_IDLE) && start && (layer != 2'd3);
      issue_c      = (state == S_FETCH) &&
                     ((3'(occ_q) + 3'(inflight_q) - 3'(pop_c)) < 3'd2);
      last_issue_c = issue_c && (issued_q == last_off_q);
      occ_next_c   = occ_q + 2'(push_c) - 2'(pop_c);
   end

   assign sram_csb = ~issue_c;

   // Controller state, read issue, and output buffer
   always_ff @(posedge clk) begin
      if (srst) begin
         state           <= S_IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         sram_raddr      <= '0;
         last_off_q      <= '0;
         issued_q        <= '0;
         occ_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_idx_q  <= '0;
         inflight_last_q <= 1'b0;
         skid_data_q     <= '0;
         skid_idx_q      <= '0;
         skid_last_q     <= 1'b0;
         w_valid         <= 1'b0;
         w_data          <= '0;
         w_index         <= '0;
         w_last          <= 1'b0;
      end else begin
         done       <= 1'b0;
         inflight_q <= issue_c;

         if (issue_c) begin
            inflight_idx_q  <= issued_q;
            inflight_last_q <= last_issue_c;
            issued_q        <= issued_q + ADDR_ONE;
            // Hold the final address so the bus never points past the layer
            if (!last_issue_c)
               sram_raddr <= sram_raddr + ADDR_ONE;
         end

         // Head register feeds the outputs; skid holds the second entry
         if ((occ_q == 2'd2) && pop_c) begin
            w_data  <= skid_data_q;
            w_index <= skid_idx_q;
            w_last  <= skid_last_q;
            if (push_c) begin
               skid_data_q <= sram_rdata;
               skid_idx_q  <= inflight_idx_q;
               skid_last_q <= inflight_last_q;
            end
         end else if (push_c && ((occ_q == 2'd0) || pop_c)) begin
            w_data  <= sram_rdata;
            w_index <= inflight_idx_q;
            w_last  <= inflight_last_q;
         end else if (push_c) begin
            skid_data_q <= sram_rdata;
            skid_idx_q  <= inflight_idx_q;
            skid_last_q <= inflight_last_q;
         end
         occ_q   <= occ_next_c;
         w_valid <= (occ_next_c != 2'd0);

         case (state)
            S_IDLE: begin
               if (start_ok_c) begin
                  state      <= S_FETCH;
                  busy       <= 1'b1;
                  sram_raddr <= base_c;
                  last_off_q <= last_off_c;
                  issued_q   <= '0;
               end
            end
            S_FETCH: begin
               if (last_issue_c)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (pop_c && w_last) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef WFETCH_CHECKSUM_EN
   logic [15:0] word_sum_c;

   // Unsigned sum of every weight field of the head word
   always_comb begin
      word_sum_c = 16'd0;
      for (int unsigned i = 0; i < WEIGHT_PER_ADDR; i++)
         word_sum_c = word_sum_c + 16'(w_data[i*BW_PER_PARAM +: BW_PER_PARAM]);
   end

   // Accumulate on every handshake; cleared by an accepted start
   always_ff @(posedge clk) begin
      if (srst)
         w_checksum <= 16'd0;
      else if (start_ok_c)
         w_checksum <= 16'd0;
      else if (pop_c)
         w_checksum <= w_checksum + word_sum_c;
   end
`else
   assign w_checksum = 16'd0;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
module tb_weight_fetch_ctrl;

   localparam int unsigned DW = 72;
   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          srst;
   logic          start;
   logic [1:0]    layer;
   logic          busy;
   logic          done;
   logic          sram_csb;
   logic [AW-1:0] sram_raddr;
   logic [DW-1:0] sram_rdata;
   logic          w_valid;
   logic          w_ready;
   logic [DW-1:0] w_data;
   logic [AW-1:0] w_index;
   logic          w_last;
   logic [15:0]   w_checksum;

   always #5 clk = ~clk;

   weight_fetch_ctrl dut (
      .clk        (clk),
      .srst       (srst),
      .start      (start),
      .layer      (layer),
      .busy       (busy),
      .done       (done),
      .sram_csb   (sram_csb),
      .sram_raddr (sram_raddr),
      .sram_rdata (sram_rdata),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_data     (w_data),
      .w_index    (w_index),
      .w_last     (w_last),
      .w_checksum (w_checksum)
   );

   // SRAM model: word i holds byte i[7:0] in all nine lanes, 1-cycle read
   logic [DW-1:0] sram_mem [0:639];
   initial sram_rdata = '0;
   always @(posedge clk)
      if (!sram_csb && sram_raddr < AW'(640))
         sram_rdata <= sram_mem[sram_raddr];

   typedef struct {
      logic [DW-1:0] data;
      logic [AW-1:0] idx;
      logic          last;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] rd_addr_q[$];
   int            checks = 0;
   int            failures = 0;
   int            done_cnt = 0;
   int            reads_cnt = 0;
   int            hs_cnt = 0;
   int            cyc = 0;
   int            last_hs_cyc = -10;
   logic [AW-1:0] rd_lo = '0;
   logic [AW-1:0] rd_hi = '0;
   logic [15:0]   model_sum = '0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [AW-1:0] prev_idx = '0;

   // Scoreboard monitor, sampled 2 time units after the falling edge
   always @(negedge clk) begin
      exp_t e;
      #2;
      cyc++;
      if (srst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (w_valid !== 1'b1 || w_data !== prev_data || w_index !== prev_idx) begin
               failures++;
               $display("FAIL hold: valid=%0b idx=%0d data=%h required valid=1 idx=%0d data=%h",
                        w_valid, w_index, w_data, prev_idx, prev_data);
            end
         end
         if (sram_csb === 1'b0) begin
            reads_cnt++;
            rd_addr_q.push_back(sram_raddr);
            checks++;
            if (sram_raddr < rd_lo || sram_raddr > rd_hi) begin
               failures++;
               $display("FAIL raddr_range: got %0d required %0d..%0d", sram_raddr, rd_lo, rd_hi);
            end
         end
         if (done === 1'b1) begin
            done_cnt++;
            checks++;
            if (cyc != last_hs_cyc + 1 || busy !== 1'b0) begin
               failures++;
               $display("FAIL done_timing: cycle=%0d busy=%0b required cycle=%0d busy=0",
                        cyc, busy, last_hs_cyc + 1);
            end
         end
         if (w_valid === 1'b1 && w_ready === 1'b1) begin
            hs_cnt++;
            for (int i = 0; i < 9; i++)
               model_sum = model_sum + 16'(w_data[i*8 +: 8]);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_word: got idx=%0d data=%h required no word", w_index, w_data);
            end else begin
               e = exp_q.pop_front();
               if (w_data !== e.data || w_index !== e.idx || w_last !== e.last) begin
                  failures++;
                  $display("FAIL word: got idx=%0d last=%0b data=%h required idx=%0d last=%0b data=%h",
                           w_index, w_last, w_data, e.idx, e.last, e.data);
               end
            end
            if (w_last === 1'b1) last_hs_cyc = cyc;
         end
         prev_stall = (w_valid === 1'b1) && (w_ready !== 1'b1);
         prev_data  = w_data;
         prev_idx   = w_index;
      end
   end

   // Pulse start for one cycle; when accepted, load the expected word stream
   task automatic do_start(input logic [1:0] l, input bit accept);
      int base;
      int cnt;
      exp_t e;
      base = (l == 2'd0) ? 0 : (l == 2'd1) ? 16 : 64;
      cnt  = (l == 2'd0) ? 16 : (l == 2'd1) ? 48 : 576;
      @(negedge clk);
      start = 1'b1;
      layer = l;
      if (accept) begin
         for (int k = 0; k < cnt; k++) begin
            e.data = {9{8'(base + k)}};
            e.idx  = AW'(k);
            e.last = (k == cnt - 1);
            exp_q.push_back(e);
         end
         rd_lo     = AW'(base);
         rd_hi     = AW'(base + cnt - 1);
         model_sum = '0;
         hs_cnt    = 0;
         reads_cnt = 0;
         rd_addr_q.delete();
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Run until done (mode 0: ready high, mode 1: ready toggles)
   task automatic run_until_done(input int mode, input int limit);
      int d0;
      int c;
      d0 = done_cnt;
      c  = 0;
      while (done_cnt == d0 && c < limit) begin
         @(negedge clk);
         w_ready = (mode == 1) ? c[0] : 1'b1;
         c++;
      end
      w_ready = 1'b1;
      checks++;
      if (done_cnt != d0 + 1) begin
         failures++;
         $display("FAIL done_wait: got %0d done pulses required 1 within %0d cycles", done_cnt - d0, limit);
      end
   endtask

   task automatic test_reset();
      srst    = 1'b1;
      start   = 1'b0;
      layer   = 2'd0;
      w_ready = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sram_csb !== 1'b1 || sram_raddr !== '0) begin
         failures++;
         $display("FAIL reset_ctrl: busy=%0b done=%0b csb=%0b raddr=%0d required 0 0 1 0",
                  busy, done, sram_csb, sram_raddr);
      end
      checks++;
      if (w_valid !== 1'b0 || w_data !== '0 || w_index !== '0 || w_last !== 1'b0 || w_checksum !== 16'd0) begin
         failures++;
         $display("FAIL reset_out: valid=%0b data=%h idx=%0d last=%0b ck=%0d required all 0",
                  w_valid, w_data, w_index, w_last, w_checksum);
      end
      @(negedge clk);
      srst = 1'b0;
   endtask

   task automatic test_conv1();
      logic [15:0] exp_ck;
      w_ready = 1'b1;
      do_start(2'd0, 1'b1);
      #2;
      checks++;
      if (busy !== 1'b1 || w_valid !== 1'b0 || sram_csb !== 1'b0 || sram_raddr !== AW'(0)) begin
         failures++;
         $display("FAIL conv1_cycle1: busy=%0b valid=%0b csb=%0b raddr=%0d required 1 0 0 0",
                  busy, w_valid, sram_csb, sram_raddr);
      end
      @(negedge clk); #2;
      checks++;
      if (w_valid !== 1'b0) begin
         failures++;
         $display("FAIL conv1_cycle2_valid: got %0b required 0", w_valid);
      end
      @(negedge clk); #2;
      checks++;
      if (w_valid !== 1'b1 || w_index !== AW'(0)) begin
         failures++;
         $display("FAIL conv1_first_valid: valid=%0b idx=%0d required 1 0", w_valid, w_index);
      end
      run_until_done(0, 100);
      repeat (3) @(negedge clk);
      #2;
`ifdef WFETCH_CHECKSUM_EN
      exp_ck = 16'd1080;
`else
      exp_ck = 16'd0;
`endif
      checks++;
      if (hs_cnt != 16 || exp_q.size() != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL conv1_count: words=%0d left=%0d busy=%0b required 16 0 0", hs_cnt, exp_q.size(), busy);
      end
      checks++;
      if (w_checksum !== exp_ck) begin
         failures++;
         $display("FAIL conv1_checksum: got %0d required %0d", w_checksum, exp_ck);
      end
   endtask

   task automatic test_conv3_toggle();
      logic [15:0] exp_ck;
      w_ready = 1'b0;
      do_start(2'd2, 1'b1);
      run_until_done(1, 3000);
      repeat (2) @(negedge clk);
      #2;
`ifdef WFETCH_CHECKSUM_EN
      exp_ck = model_sum;
`else
      exp_ck = 16'd0;
`endif
      checks++;
      if (hs_cnt != 576 || exp_q.size() != 0 || reads_cnt != 576) begin
         failures++;
         $display("FAIL conv3_count: words=%0d left=%0d reads=%0d required 576 0 576",
                  hs_cnt, exp_q.size(), reads_cnt);
      end
      checks++;
      if (w_checksum !== exp_ck) begin
         failures++;
         $display("FAIL conv3_checksum: got %0d required %0d", w_checksum, exp_ck);
      end
   endtask

   task automatic test_conv2_stall();
      logic [DW-1:0] w16;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      w16 = {9{8'd16}};
      w_ready = 1'b0;
      do_start(2'd1, 1'b1);
      repeat (10) @(negedge clk);
      #2;
      a0 = (rd_addr_q.size() > 0) ? rd_addr_q[0] : '1;
      a1 = (rd_addr_q.size() > 1) ? rd_addr_q[1] : '1;
      checks++;
      if (reads_cnt != 2 || a0 !== AW'(16) || a1 !== AW'(17)) begin
         failures++;
         $display("FAIL conv2_stall_reads: reads=%0d addr0=%0d addr1=%0d required 2 16 17", reads_cnt, a0, a1);
      end
      checks++;
      if (w_valid !== 1'b1 || w_data !== w16) begin
         failures++;
         $display("FAIL conv2_stall_head: valid=%0b data=%h required 1 %h", w_valid, w_data, w16);
      end
      run_until_done(0, 300);
      @(negedge clk);
      checks++;
      if (hs_cnt != 48 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL conv2_count: words=%0d left=%0d required 48 0", hs_cnt, exp_q.size());
      end
   endtask

   task automatic test_illegal_and_ignored_start();
      int d0;
      int r0;
      w_ready = 1'b1;
      d0 = done_cnt;
      r0 = reads_cnt;
      do_start(2'd3, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #2;
         checks++;
         if (busy !== 1'b0 || sram_csb !== 1'b1) begin
            failures++;
            $display("FAIL illegal_layer: busy=%0b csb=%0b required 0 1", busy, sram_csb);
         end
      end
      checks++;
      if (done_cnt != d0 || reads_cnt != r0) begin
         failures++;
         $display("FAIL illegal_layer_done: done=%0d reads=%0d required 0 0", done_cnt - d0, reads_cnt - r0);
      end
      d0 = done_cnt;
      do_start(2'd2, 1'b1);
      repeat (20) @(negedge clk);
      do_start(2'd0, 1'b0);
      run_until_done(0, 1000);
      repeat (5) @(negedge clk);
      #2;
      checks++;
      if (done_cnt != d0 + 1 || hs_cnt != 576 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL ignored_start: done=%0d words=%0d left=%0d required 1 576 0",
                  done_cnt - d0, hs_cnt, exp_q.size());
      end
   endtask

   task automatic test_srst_abort();
      int d0;
      w_ready = 1'b1;
      d0 = done_cnt;
      do_start(2'd1, 1'b1);
      repeat (4) @(negedge clk);
      srst = 1'b1;
      @(negedge clk); #2;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || sram_csb !== 1'b1 || sram_raddr !== '0 ||
          w_valid !== 1'b0 || w_data !== '0 || w_index !== '0 || w_last !== 1'b0 || w_checksum !== 16'd0) begin
         failures++;
         $display("FAIL srst_abort: busy=%0b done=%0b csb=%0b raddr=%0d valid=%0b idx=%0d last=%0b ck=%0d required reset values",
                  busy, done, sram_csb, sram_raddr, w_valid, w_index, w_last, w_checksum);
      end
      exp_q.delete();
      srst = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      checks++;
      if (done_cnt != d0 || w_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL srst_no_done: done=%0d valid=%0b busy=%0b required 0 0 0", done_cnt - d0, w_valid, busy);
      end
      do_start(2'd0, 1'b1);
      run_until_done(0, 100);
      @(negedge clk);
      checks++;
      if (hs_cnt != 16 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL srst_restart: words=%0d left=%0d required 16 0", hs_cnt, exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 640; i++)
         sram_mem[i] = {9{8'(i)}};
      test_reset();
      test_conv1();
      test_conv3_toggle();
      test_conv2_stall();
      test_illegal_and_ignored_start();
      test_srst_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Weight fetch controller: the read-side initiator for the 640x72b weight SRAM. On a per-layer start command it streams that layer's weight words out of the SRAM in address order and delivers them to the convolution datapath over a valid/ready handshake. It absorbs the SRAM's 1-cycle registered read latency and downstream back-pressure with a 2-entry output buffer, so no word is lost or duplicated.

## Interface
- WEIGHT_PER_ADDR, 9, weights per SRAM word
- BW_PER_PARAM, 8, bits per weight
- ADDR_BW, 10, SRAM address width
- clk  in  1  rising-edge clock
- srst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to fetch a layer; sampled only in IDLE
- layer  in  2  0=conv1, 1=conv2, 2=conv3, 3=illegal; sampled with start
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last word's handshake
- sram_csb  out  1  SRAM chip enable, active-low (read strobe)
- sram_raddr  out  ADDR_BW  SRAM read address
- sram_rdata  in  WEIGHT_PER_ADDR*BW_PER_PARAM  SRAM read data, valid the cycle after the read edge
- w_valid  out  1  output word valid
- w_ready  in  1  downstream accept
- w_data  out  WEIGHT_PER_ADDR*BW_PER_PARAM  weight word
- w_index  out  ADDR_BW  word offset within the layer, 0-based
- w_last  out  1  marks the layer's final word
- w_checksum  out  16  running checksum (see Configuration)

## Operation
- Layer map, fixed (base, count): conv1 (0, 16); conv2 (16, 48); conv3 (64, 576).
- FSM states:
  - IDLE: start && layer!=3 -> latch base and count, go to FETCH. start with layer==3 is dropped with no busy and no done.
  - FETCH: issue reads until count reads have been issued, then go to DRAIN.
  - DRAIN: stay until the last word's handshake completes, then pulse done and go to IDLE.
- Read issue: sram_csb=0 with sram_raddr=base+issued. A read is issued in a cycle only if buffer occupancy + in-flight reads - (pop this cycle) < 2. Otherwise sram_csb=1.
- A read issued in cycle N returns in cycle N+1. It is pushed into the FIFO at the end of cycle N+1.
- FIFO: 2 entries, in order. The head drives w_data, w_index, w_last. A handshake (w_valid && w_ready) pops the head. Push and pop may occur in the same cycle.
- w_valid, once high, holds with stable data until accepted.
- start during FETCH or DRAIN is ignored.
- The read address never leaves [base, base+count-1]. The block never writes the SRAM.

## Timing
- Reset values: state IDLE, busy=0, done=0, sram_csb=1, sram_raddr=0, w_valid=0, w_data=0, w_index=0, w_last=0, w_checksum=0. The FIFO is emptied and any in-flight read is discarded.
- srst during FETCH or DRAIN aborts the fetch: no done pulse, outputs return to reset values on the next cycle.
- start accepted at edge E0:
  - busy=1 and the first read is issued in the cycle after E0.
  - Data is pushed at E2, so w_valid rises in the cycle after E2.
  - Start-to-first-valid latency is 2 cycles.
- With w_ready held high the block sustains 1 word per cycle. conv1 completes its last handshake 17 cycles after E0. done pulses the following cycle, and busy falls in the same cycle as done.
- With w_ready low, at most 2 words are buffered. Reads stall until space frees, and the first read after space frees returns 1 cycle later. There are no bubbles beyond this refill latency.

## Configuration
- WFETCH_CHECKSUM_EN defined:
  - w_checksum = modulo-2^16 sum of every unsigned BW_PER_PARAM field of every word handshaked since the accepted start.
  - It is cleared on the accepted start and holds its final value after done until the next start.
- WFETCH_CHECKSUM_EN undefined: no accumulator is built and w_checksum is tied to 0.

## Test plan
- Preload SRAM word i with all 9 bytes = i[7:0]. Start with layer=0 and w_ready=1 -> 16 words on indices 0..15 with data bytes 0x00..0x0F, w_last on index 15, done 1 cycle after. With the macro, w_checksum=9*120=1080.
- layer=2 with w_ready toggling 1/0 each cycle -> 576 words from addresses 64..639 in order, no duplicates or drops, and sram_raddr never exceeds 639.
- layer=1 with w_ready=0 for 10 cycles after start -> only 2 reads are issued (addresses 16 and 17) and w_data holds the address-16 word. After ready rises, all 48 words arrive in order.
- start with layer=3 -> busy stays 0, sram_csb stays 1, no done. A second start pulse during conv3 busy is ignored and produces exactly one done.
- srst asserted 5 cycles into conv2 -> all outputs at reset values the next cycle, no done. A fresh conv1 start then yields exactly 16 correct words.
